// File: rtl/pll_lock_reset_sequencer.sv
// Turns the raw, asynchronous PLL lock into a debounced active-high design reset
// in the PLL output clock domain, re-sequencing on qualified lock loss or soft request.
module pll_lock_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int GLITCH_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_locked,
    input  logic       i_soft_req,
    output logic       o_rst_out,
    output logic       o_ready,
    output logic [7:0] o_lock_loss_cnt
);

    localparam int MAX_CYCLES =
        (STABLE_CYCLES > HOLD_CYCLES)
            ? ((STABLE_CYCLES > GLITCH_CYCLES) ? STABLE_CYCLES : GLITCH_CYCLES)
            : ((HOLD_CYCLES > GLITCH_CYCLES) ? HOLD_CYCLES : GLITCH_CYCLES);

    // Out-of-range parameters stop elaboration rather than building a broken sequencer.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || GLITCH_CYCLES < 1) begin : g_bad_cycles
        $error("STABLE_CYCLES, HOLD_CYCLES and GLITCH_CYCLES must be >= 1");
    end
    if (CNT_W < 1 || (CNT_W < 31 && MAX_CYCLES >= (32'sd1 << CNT_W))) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the largest cycle count");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_loss;
    logic                   w_lock_s;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Next-state and phase-counter decode; in RUN the counter measures the current low run.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss      = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                // A qualifying loss outranks a simultaneous soft request.
                if (!w_lock_s && (r_cnt == GLITCH_LAST)) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                    w_loss      = 1'b1;
                end else if (i_soft_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (!w_lock_s) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Synchronizer, state, counters and outputs; outputs decode the next state so they stay glitch-free.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_sync          <= {SYNC_STAGES{1'b0}};
            r_state         <= ST_WAIT_LOCK;
            r_cnt           <= CNT_ZERO;
            o_rst_out       <= 1'b1;
            o_ready         <= 1'b0;
            o_lock_loss_cnt <= 8'd0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_locked};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            o_rst_out <= (w_state_nxt != ST_RUN);
            o_ready   <= (w_state_nxt == ST_RUN);
            if (w_loss && (o_lock_loss_cnt != 8'hFF)) begin
                o_lock_loss_cnt <= o_lock_loss_cnt + 8'd1;
            end else begin
                o_lock_loss_cnt <= o_lock_loss_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench for pll_lock_reset_sequencer: directed scenarios plus a randomized run
// compared against a run-length reference model of the lock/reset sequence.
module tb_pll_lock_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int GLITCH = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       locked;
    logic       soft_req;
    logic       rst_out;
    logic       ready;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: lock_s delay line, length of the current lock-high run within
    // the present sequencing attempt, length of the low run while running.
    int m_q[$];
    int m_seq_hi = 0;
    int m_low    = 0;
    bit m_running = 1'b0;
    int m_loss   = 0;

    pll_lock_reset_sequencer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD),
        .GLITCH_CYCLES(GLITCH),
        .CNT_W        (16)
    ) dut (
        .i_clock        (clk),
        .i_resetn       (resetn),
        .i_locked       (locked),
        .i_soft_req     (soft_req),
        .o_rst_out      (rst_out),
        .o_ready        (ready),
        .o_lock_loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    // One clock edge: advance the model with the inputs the DUT sampled, then settle.
    task step;
        int ls;
        @(posedge clk);
        if (!resetn) begin
            m_q = {};
            for (int i = 0; i < SYNC; i++) m_q.push_back(0);
            m_seq_hi  = 0;
            m_low     = 0;
            m_running = 1'b0;
            m_loss    = 0;
        end else begin
            ls = m_q.pop_front();
            m_q.push_back(int'(locked));
            if (!m_running) begin
                m_seq_hi = (ls != 0) ? m_seq_hi + 1 : 0;
                if (m_seq_hi == 1 + STABLE + HOLD) begin
                    m_running = 1'b1;
                    m_low     = 0;
                end
            end else begin
                m_low = (ls == 0) ? m_low + 1 : 0;
                if (m_low == GLITCH) begin
                    m_running = 1'b0;
                    m_seq_hi  = 0;
                    if (m_loss < 255) m_loss++;
                end else if (soft_req) begin
                    m_running = 1'b0;
                    m_seq_hi  = 1 + STABLE;
                    m_low     = 0;
                end
            end
        end
        #1;
    endtask

    task test_reset;
        resetn = 1'b0; locked = 1'b1; soft_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks += 3;
            if (rst_out !== 1'b1) begin n_fail++; $display("FAIL reset_rst: got %b expected 1", rst_out); end
            if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
            if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d expected 0", loss_cnt); end
        end
    endtask

    task test_lock_sequence;
        int falls;
        logic prev;
        resetn = 1'b0; locked = 1'b0; soft_req = 1'b0;
        step();
        resetn = 1'b1; locked = 1'b1;
        falls = 0; prev = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            n_checks += 2;
            if (rst_out !== (e < 15)) begin n_fail++; $display("FAIL seq_rst e=%0d: got %b expected %b", e, rst_out, (e < 15)); end
            if (ready !== (e >= 15)) begin n_fail++; $display("FAIL seq_ready e=%0d: got %b expected %b", e, ready, (e >= 15)); end
            if (prev !== rst_out) falls++;
            prev = rst_out;
        end
        n_checks++;
        if (falls != 1) begin n_fail++; $display("FAIL seq_single_edge: got %0d transitions expected 1", falls); end
    endtask

    task test_stable_glitch;
        resetn = 1'b0; locked = 1'b0;
        step();
        resetn = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            locked = (e == 7) ? 1'b0 : 1'b1;
            step();
            n_checks++;
            if (rst_out !== (e < 22)) begin n_fail++; $display("FAIL stable_glitch_rst e=%0d: got %b expected %b", e, rst_out, (e < 22)); end
        end
    endtask

    task test_run_glitch;
        for (int k = 1; k <= 10; k++) begin
            locked = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            step();
            n_checks += 2;
            if (rst_out !== 1'b0) begin n_fail++; $display("FAIL short_glitch_rst k=%0d: got %b expected 0", k, rst_out); end
            if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL short_glitch_loss k=%0d: got %0d expected 0", k, loss_cnt); end
        end
        for (int k = 1; k <= 8; k++) begin
            locked = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            step();
            n_checks += 2;
            if (rst_out !== (k >= 7)) begin n_fail++; $display("FAIL loss_rst k=%0d: got %b expected %b", k, rst_out, (k >= 7)); end
            if (loss_cnt !== ((k >= 7) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL loss_cnt k=%0d: got %0d expected %0d", k, loss_cnt, (k >= 7) ? 1 : 0); end
        end
    endtask

    task test_soft_req;
        resetn = 1'b0; locked = 1'b1; soft_req = 1'b0;
        step();
        resetn = 1'b1;
        for (int e = 1; e <= 16; e++) step();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= 6; k++) begin
                soft_req = (k == 1 || (pass == 1 && k == 3)) ? 1'b1 : 1'b0;
                step();
                n_checks += 2;
                if (rst_out !== (k <= 4)) begin n_fail++; $display("FAIL soft_rst pass=%0d k=%0d: got %b expected %b", pass, k, rst_out, (k <= 4)); end
                if (ready !== (k > 4)) begin n_fail++; $display("FAIL soft_ready pass=%0d k=%0d: got %b expected %b", pass, k, ready, (k > 4)); end
            end
        end
        soft_req = 1'b0;
    endtask

    task test_saturation;
        int exp;
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            for (int k = 0; k < 4; k++) step();
            locked = 1'b1;
            for (int k = 0; k < 20; k++) step();
            exp = (i + 1 > 255) ? 255 : i + 1;
            n_checks++;
            if (loss_cnt !== 8'(exp)) begin n_fail++; $display("FAIL sat_loss i=%0d: got %0d expected %0d", i, loss_cnt, exp); end
        end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready: got %b expected 1", ready); end
        soft_req = 1'b1; step();
        soft_req = 1'b0; step();
        resetn = 1'b0; step();
        n_checks += 3;
        if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL hold_reset_loss: got %0d expected 0", loss_cnt); end
        if (rst_out !== 1'b1) begin n_fail++; $display("FAIL hold_reset_rst: got %b expected 1", rst_out); end
        if (ready !== 1'b0) begin n_fail++; $display("FAIL hold_reset_ready: got %b expected 0", ready); end
        resetn = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            if (e == 14 || e == 15) begin
                n_checks++;
                if (rst_out !== (e == 14)) begin n_fail++; $display("FAIL hold_reset_resync e=%0d: got %b expected %b", e, rst_out, (e == 14)); end
            end
        end
    endtask

    task test_random;
        int remaining;
        bit lv;
        resetn = 1'b0; locked = 1'b0; soft_req = 1'b0;
        step();
        resetn = 1'b1;
        remaining = 0; lv = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (remaining == 0) begin
                lv = ~lv;
                remaining = lv ? $urandom_range(40, 1) : $urandom_range(5, 1);
            end
            remaining--;
            locked   = lv;
            soft_req = ($urandom_range(29, 0) == 0);
            resetn   = ($urandom_range(799, 0) != 0);
            step();
            n_checks += 3;
            if (rst_out !== !m_running) begin n_fail++; $display("FAIL rand_rst c=%0d: got %b expected %b", c, rst_out, !m_running); end
            if (ready !== m_running) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, ready, m_running); end
            if (loss_cnt !== 8'(m_loss)) begin n_fail++; $display("FAIL rand_loss c=%0d: got %0d expected %0d", c, loss_cnt, m_loss); end
        end
        resetn = 1'b1; soft_req = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; locked = 1'b0; soft_req = 1'b0;
        test_reset();
        test_lock_sequence();
        test_stable_glitch();
        test_run_glitch();
        test_soft_req();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
